// File: rtl/psram_responder_if.sv
// Device-side PSRAM link: chip enable and SIO pins seen by the responder, plus its status outputs.
interface psram_responder_if;
  logic       mem_ce;
  logic [3:0] sio_in;
  logic [3:0] sio_out;
  logic [3:0] sio_oe;
  logic       qpi_mode;
  logic [7:0] last_cmd;
  logic       cmd_err;
  logic       prot_err;

  modport master (
    output mem_ce, sio_in,
    input  sio_out, sio_oe, qpi_mode, last_cmd, cmd_err, prot_err
  );

  modport slave (
    input  mem_ce, sio_in,
    output sio_out, sio_oe, qpi_mode, last_cmd, cmd_err, prot_err
  );
endinterface

// File: rtl/psram_responder.sv
// PSRAM device-side responder: SPI init decode (66/99/35), QPI read EB / write 02 on a byte array.
// Optional sticky protocol checker enabled by defining PSRAM_PROTOCOL_CHECK_EN.
module psram_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 6
) (
  input  logic             mem_clk,
  input  logic             rst_n,
  psram_responder_if.slave bus
);
  localparam int WC_W = $clog2(WAIT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, SPI_CMD, QPI_CMD, ADDR, WAIT, RD_DATA, WR_DATA, IGNORE
  } state_t;

  state_t            state, state_nx;
  logic [7:0]        mem [2**ADDR_W];
  logic [7:0]        shift;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] ptr;
  logic [WC_W-1:0]   wcnt;
  logic [3:0]        hi;
  logic              phase, rd, ovf;
  logic              qpi, armed, cmd_err_q;
  logic              qpi_nx, armed_nx, cmd_err_nx, dec_en;
  logic [7:0]        last_q;
  logic [3:0]        out_q;
  logic              oe_q;
  logic              ce;
  logic [3:0]        sio;
  logic [7:0]        qbyte;

  assign ce    = bus.mem_ce;
  assign sio   = bus.sio_in;
  assign qbyte = {shift[7:4], sio};

  assign bus.sio_out  = out_q;
  assign bus.sio_oe   = {4{oe_q & ~ce}};
  assign bus.qpi_mode = qpi;
  assign bus.last_cmd = last_q;
  assign bus.cmd_err  = cmd_err_q;

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      qpi       <= 1'b0;
      armed     <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      state     <= state_nx;
      qpi       <= qpi_nx;
      armed     <= armed_nx;
      cmd_err_q <= cmd_err_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    qpi_nx     = qpi;
    armed_nx   = armed;
    cmd_err_nx = 1'b0;
    dec_en     = 1'b0;
    case (state)
      IDLE:    if (!ce) state_nx = qpi ? QPI_CMD : SPI_CMD;
      SPI_CMD: begin
        if (ce) begin
          state_nx = IDLE;
          if (cnt == 4'd8) dec_en = 1'b1;
          else             cmd_err_nx = 1'b1;
        end else if (cnt == 4'd8) begin
          state_nx = IGNORE;
        end
      end
      QPI_CMD: begin
        if (ce) begin
          state_nx = IDLE;
          if (cnt == 4'd2) dec_en = 1'b1;
          else             cmd_err_nx = 1'b1;
        end else if (cnt == 4'd1) begin
          // reset/exit opcodes wait for CE rise; data opcodes proceed to address
          case (qbyte)
            8'hEB, 8'h02:        state_nx = ADDR;
            8'h66, 8'h99, 8'hF5: state_nx = QPI_CMD;
            default: begin
              cmd_err_nx = 1'b1;
              state_nx   = IGNORE;
            end
          endcase
        end else begin
          state_nx = IGNORE;
        end
      end
      ADDR: begin
        if (ce)               state_nx = IDLE;
        else if (cnt == 4'd5) state_nx = rd ? WAIT : WR_DATA;
      end
      WAIT: begin
        if (ce)                                  state_nx = IDLE;
        else if (wcnt == WC_W'(WAIT_CYCLES - 1)) state_nx = RD_DATA;
      end
      RD_DATA, WR_DATA: if (ce) state_nx = IDLE;
      IGNORE: begin
        if (ce) begin
          state_nx   = IDLE;
          cmd_err_nx = ovf;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (dec_en) begin
      armed_nx = 1'b0;
      case (shift)
        8'h66: armed_nx = 1'b1;
        8'h99: if (armed) qpi_nx = 1'b0; else cmd_err_nx = 1'b1;
        8'h35: if (!qpi)  qpi_nx = 1'b1; else cmd_err_nx = 1'b1;
        8'hF5: if (qpi)   qpi_nx = 1'b0; else cmd_err_nx = 1'b1;
        default: cmd_err_nx = 1'b1;
      endcase
    end
  end

  // Address nibbles shift straight into ptr; only the low ADDR_W bits survive.
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      shift  <= '0;
      cnt    <= '0;
      ptr    <= '0;
      wcnt   <= '0;
      hi     <= '0;
      phase  <= 1'b0;
      rd     <= 1'b0;
      ovf    <= 1'b0;
      last_q <= '0;
    end else if (!ce) begin
      case (state)
        IDLE: begin
          cnt   <= 4'd1;
          ovf   <= 1'b0;
          shift <= qpi ? {sio, 4'h0} : {7'h0, sio[0]};
        end
        SPI_CMD: begin
          if (cnt != 4'd8) begin
            shift <= {shift[6:0], sio[0]};
            cnt   <= cnt + 4'd1;
            if (cnt == 4'd7) last_q <= {shift[6:0], sio[0]};
          end else begin
            ovf <= 1'b1;
          end
        end
        QPI_CMD: begin
          if (cnt == 4'd1) begin
            shift  <= qbyte;
            last_q <= qbyte;
            rd     <= (qbyte == 8'hEB);
            cnt    <= (qbyte == 8'hEB || qbyte == 8'h02) ? 4'd0 : 4'd2;
          end else begin
            ovf <= 1'b1;
          end
        end
        ADDR: begin
          ptr   <= ADDR_W'({ptr, sio});
          cnt   <= cnt + 4'd1;
          wcnt  <= '0;
          phase <= 1'b0;
        end
        WAIT:    wcnt <= wcnt + WC_W'(1);
        RD_DATA: begin
          phase <= ~phase;
          if (phase) ptr <= ptr + ADDR_W'(1);
        end
        WR_DATA: begin
          phase <= ~phase;
          if (!phase) hi <= sio;
          else        ptr <= ptr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge mem_clk) begin
    if (state == WR_DATA && !ce && phase) mem[ptr] <= {hi, sio};
  end

  // Read nibbles launch on negedge so the initiator samples them on the next posedge.
  always_ff @(negedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      oe_q  <= 1'b0;
    end else if (state == RD_DATA) begin
      oe_q  <= 1'b1;
      out_q <= phase ? mem[ptr][3:0] : mem[ptr][7:4];
    end else begin
      oe_q  <= 1'b0;
    end
  end

`ifdef PSRAM_PROTOCOL_CHECK_EN
  logic prot_set, prot_q;

  always_comb begin
    prot_set = 1'b0;
    case (state)
      SPI_CMD: begin
        if (ce) prot_set = (cnt != 4'd8) || (shift == 8'hEB) || (shift == 8'h02);
        else    prot_set = (cnt == 4'd8);
      end
      ADDR, WAIT: prot_set = ce;
      default: ;
    endcase
`ifndef SYNTHESIS
    if (!ce && state != IGNORE && $isunknown(sio)) prot_set = 1'b1;
`endif
  end

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n)        prot_q <= 1'b0;
    else if (prot_set) prot_q <= 1'b1;
  end

  assign bus.prot_err = prot_q;
`else
  assign bus.prot_err = 1'b0;
`endif
endmodule
